// File: rtl/lc3b_ctrl_seq.sv
// lc3b_ctrl_seq: multi-cycle LC-3b microsequencer with variable-latency memory handshake.
// Define CTRL_MEMTMO_EN to enable the memory-wait timeout that halts and sets mem_err.
module lc3b_ctrl_seq #(
    parameter int IR_W = 16,
    parameter int ALUOP_W = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IR_W-1:0]    IR,
    input  logic               N,
    input  logic               Z,
    input  logic               P,
    input  logic               R,
    output logic [ALUOP_W-1:0] aluop,
    output logic               LDCC,
    output logic               LDIR,
    output logic               LDREG,
    output logic               LDPC,
    output logic               LDMAR,
    output logic               LDMDR,
    output logic               MEMEN,
    output logic               MEMWE,
    output logic [1:0]         PCMUX,
    output logic               halt,
    output logic               illegal,
    output logic               mem_err,
    output logic [3:0]         state
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F_MAR  = 4'd1;
    localparam logic [3:0] S_F_MEM  = 4'd2;
    localparam logic [3:0] S_F_IR   = 4'd3;
    localparam logic [3:0] S_DECODE = 4'd4;
    localparam logic [3:0] S_ALU    = 4'd5;
    localparam logic [3:0] S_BR     = 4'd6;
    localparam logic [3:0] S_JMP    = 4'd7;
    localparam logic [3:0] S_LEA    = 4'd8;
    localparam logic [3:0] S_LD_MAR = 4'd9;
    localparam logic [3:0] S_LD_MEM = 4'd10;
    localparam logic [3:0] S_LD_REG = 4'd11;
    localparam logic [3:0] S_ST_MAR = 4'd12;
    localparam logic [3:0] S_ST_MDR = 4'd13;
    localparam logic [3:0] S_ST_MEM = 4'd14;
    localparam logic [3:0] S_HALT   = 4'd15;

    if (MEM_WAIT_MAX < 1 || MEM_WAIT_MAX > 255) begin : g_bad_param
        $error("MEM_WAIT_MAX out of range 1..255");
    end

    logic [3:0] st, nxt, dec;
    logic       legal, mem_wait, timeout, unused_ir;
    logic [3:0] opcode;
    logic [2:0] nzp;

    assign opcode    = IR[IR_W-1 -: 4];
    assign nzp       = IR[IR_W-5 -: 3];
    assign unused_ir = ^IR[IR_W-8:0];
    assign mem_wait  = st == S_F_MEM || st == S_LD_MEM || st == S_ST_MEM;
    assign state     = st;

`ifdef CTRL_MEMTMO_EN
    logic [7:0] cnt;
    logic       err;
    // The wait states are never back to back, so clearing outside them covers "clear on entry".
    assign timeout = mem_wait && !R && cnt == 8'(MEM_WAIT_MAX - 1);
    assign mem_err = err;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
            err <= 1'b0;
        end else begin
            cnt <= (mem_wait && !R) ? cnt + 8'd1 : 8'd0;
            err <= err | timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        dec   = S_F_MAR;
        legal = 1'b1;
        case (opcode)
            4'b0001, 4'b0101, 4'b1001: dec = S_ALU;
            4'b0000: dec = S_BR;
            4'b1100: dec = S_JMP;
            4'b1110: dec = S_LEA;
            4'b0110: dec = S_LD_MAR;
            4'b0111: dec = S_ST_MAR;
            4'b1111: dec = S_HALT;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_F_MAR;
        case (st)
            S_F_MAR:  nxt = S_F_MEM;
            S_F_MEM:  nxt = timeout ? S_HALT : R ? S_F_IR : S_F_MEM;
            S_F_IR:   nxt = S_DECODE;
            S_DECODE: nxt = dec;
            S_LD_MAR: nxt = S_LD_MEM;
            S_LD_MEM: nxt = timeout ? S_HALT : R ? S_LD_REG : S_LD_MEM;
            S_ST_MAR: nxt = S_ST_MDR;
            S_ST_MDR: nxt = S_ST_MEM;
            S_ST_MEM: nxt = timeout ? S_HALT : R ? S_F_MAR : S_ST_MEM;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_F_MAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) st <= S_IDLE;
        else st <= nxt;
    end

    assign aluop   = st == S_ALU ? (opcode == 4'b0001 ? ALUOP_W'(0) : opcode == 4'b0101 ? ALUOP_W'(1) : ALUOP_W'(2))
                   : (st == S_LEA || st == S_LD_REG || st == S_ST_MDR) ? ALUOP_W'(3) : ALUOP_W'(0);
    assign LDCC    = st == S_ALU || st == S_LD_REG;
    assign LDIR    = st == S_F_IR;
    assign LDREG   = st == S_ALU || st == S_LEA || st == S_LD_REG;
    assign LDPC    = st == S_F_MAR || st == S_JMP || (st == S_BR && |(nzp & {N, Z, P}));
    assign LDMAR   = st == S_F_MAR || st == S_LD_MAR || st == S_ST_MAR;
    assign LDMDR   = st == S_F_MEM || st == S_LD_MEM || st == S_ST_MDR;
    assign MEMEN   = mem_wait;
    assign MEMWE   = st == S_ST_MEM;
    assign PCMUX   = st == S_BR ? 2'd1 : st == S_JMP ? 2'd2 : 2'd0;
    assign halt    = st == S_HALT;
    assign illegal = st == S_DECODE && !legal;
endmodule

// File: tb/tb_lc3b_ctrl_seq.sv
// tb_lc3b_ctrl_seq: scoreboard bench for lc3b_ctrl_seq with an instruction-level reference model.
module tb_lc3b_ctrl_seq;
    localparam int MWM = 4;

    typedef struct packed {
        logic [1:0] aluop;
        logic ldcc, ldir, ldreg, ldpc, ldmar, ldmdr, memen, memwe;
        logic [1:0] pcmux;
        logic halt, illegal, mem_err;
        logic [3:0] state;
    } outs_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] IR = 16'h0;
    logic N = 1'b0, Z = 1'b0, P = 1'b0, R = 1'b0;
    logic [1:0] aluop, PCMUX;
    logic LDCC, LDIR, LDREG, LDPC, LDMAR, LDMDR, MEMEN, MEMWE, halt, illegal, mem_err;
    logic [3:0] state;
    outs_t act;

    outs_t q[$];
    int errors = 0, checks = 0;
    int ms = 0, waits = 0;
    logic merr = 1'b0;

    always #5 clk = ~clk;

    lc3b_ctrl_seq #(.IR_W(16), .ALUOP_W(2), .MEM_WAIT_MAX(MWM)) dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .R(R),
        .aluop(aluop), .LDCC(LDCC), .LDIR(LDIR), .LDREG(LDREG), .LDPC(LDPC),
        .LDMAR(LDMAR), .LDMDR(LDMDR), .MEMEN(MEMEN), .MEMWE(MEMWE), .PCMUX(PCMUX),
        .halt(halt), .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    assign act = {aluop, LDCC, LDIR, LDREG, LDPC, LDMAR, LDMDR, MEMEN, MEMWE,
                  PCMUX, halt, illegal, mem_err, state};

    function automatic logic supported(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h5, 4'h9, 4'hC, 4'hE, 4'h6, 4'h7, 4'hF};
    endfunction

    // Expected control word for the phase the instruction is in.
    function automatic outs_t model_out(input int s, input logic [15:0] ir,
                                        input logic n, z, p, err);
        outs_t o = '0;
        logic [3:0] op = ir[15:12];
        o.state = 4'(s);
        o.mem_err = err;
        case (s)
            1: begin o.ldmar = 1; o.ldpc = 1; end
            2, 10: begin o.memen = 1; o.ldmdr = 1; end
            3: o.ldir = 1;
            4: o.illegal = !supported(op);
            5: begin o.ldreg = 1; o.ldcc = 1; o.aluop = op == 4'h1 ? 2'd0 : op == 4'h5 ? 2'd1 : 2'd2; end
            6: begin o.pcmux = 2'd1; o.ldpc = (ir[11] & n) | (ir[10] & z) | (ir[9] & p); end
            7: begin o.pcmux = 2'd2; o.ldpc = 1; end
            8: begin o.ldreg = 1; o.aluop = 2'd3; end
            9, 12: o.ldmar = 1;
            11: begin o.ldreg = 1; o.ldcc = 1; o.aluop = 2'd3; end
            13: begin o.ldmdr = 1; o.aluop = 2'd3; end
            14: begin o.memen = 1; o.memwe = 1; end
            15: o.halt = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic int model_next(input int s, input logic [3:0] op, input logic r, tmo);
        int tgt;
        if (tmo) return 15;
        case (op)
            4'h1, 4'h5, 4'h9: tgt = 5;
            4'h0: tgt = 6;
            4'hC: tgt = 7;
            4'hE: tgt = 8;
            4'h6: tgt = 9;
            4'h7: tgt = 12;
            4'hF: tgt = 15;
            default: tgt = 1;
        endcase
        case (s)
            0: return 1;
            1: return 2;
            2: return r ? 3 : 2;
            3: return 4;
            4: return tgt;
            9: return 10;
            10: return r ? 11 : 10;
            12: return 13;
            13: return 14;
            14: return r ? 1 : 14;
            15: return 15;
            default: return 1;
        endcase
    endfunction

    task automatic step(input logic rs, input logic [15:0] ir, input logic n, z, p, r);
        logic mem, tmo;
        reset = rs; IR = ir; N = n; Z = z; P = p; R = r;
        q.push_back(model_out(ms, ir, n, z, p, merr));
        mem = ms == 2 || ms == 10 || ms == 14;
        tmo = 1'b0;
`ifdef CTRL_MEMTMO_EN
        tmo = mem && !r && waits + 1 == MWM;
        waits = (mem && !r) ? waits + 1 : 0;
        merr = merr | tmo;
`endif
        ms = model_next(ms, ir[15:12], r, tmo);
        if (rs) begin ms = 0; waits = 0; merr = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic run(input int cnt, input logic [15:0] ir, input logic n, z, p, r);
        for (int i = 0; i < cnt; i++) step(1'b0, ir, n, z, p, r);
    endtask

    initial begin
        outs_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl_word state=%0d: got %h want %h", e.state, act, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] ops [12] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'hE, 4'h6, 4'h7, 4'hF, 4'h8, 4'h2, 4'hD};
        logic [15:0] rir;
        @(posedge clk); #1;
        ms = 0;
        run(7, 16'h1042, 0, 0, 0, 1);
        run(4, 16'h0A02, 0, 1, 0, 1);
        run(5, 16'h0A02, 0, 0, 1, 1);
        run(5, 16'h6000, 0, 0, 0, 1);
        run(3, 16'h6000, 0, 0, 0, 0);
        run(3, 16'h6000, 0, 0, 0, 1);
        run(7, 16'h7000, 0, 0, 0, 1);
        run(8, 16'hC000, 0, 0, 0, 1);
        run(5, 16'hE000, 0, 0, 0, 1);
        run(25, 16'hF025, 0, 0, 0, 1);
        step(1, 16'hF025, 0, 0, 0, 1);
        run(7, 16'h8000, 0, 0, 0, 1);
        step(1, 16'h8000, 0, 0, 0, 1);
        run(6, 16'h6000, 0, 0, 0, 1);
        run(2, 16'h6000, 0, 0, 0, 0);
        step(1, 16'h6000, 0, 0, 0, 0);
        run(1, 16'h1042, 0, 0, 0, 1);
        run(30, 16'h1042, 0, 0, 0, 0);
        step(1, 16'h1042, 0, 0, 0, 1);
        rir = 16'h1042;
        for (int i = 0; i < 1500; i++) begin
            if (ms == 1) rir = {ops[$urandom_range(0, 11)], 12'($urandom)};
            step(($urandom_range(0, 49) == 0) || (ms == 15 && $urandom_range(0, 7) == 0),
                 rir, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
